// File: rtl/global_buffer_param.sv
// Global buffer bank geometry shared by every bank-side block.
package global_buffer_param;

    localparam int BANK_ADDR_WIDTH = 16;
    localparam int BANK_DATA_WIDTH = 64;

endpackage

// File: rtl/global_buffer_pkg.sv
// Global buffer requester identities and bank read timing defaults.
package global_buffer_pkg;

    typedef enum logic [1:0] {
        REQ_PROC = 2'd0,
        REQ_STRM = 2'd1,
        REQ_PCFG = 2'd2
    } glb_req_id_e;

    localparam int GLB_RD_LATENCY = 3;

endpackage

// File: rtl/glb_rr_arbiter.sv
// Round-robin pick: one-hot grant to the first set request at or after ptr.
module glb_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned N = NUM_REQ;

    logic        found;
    int unsigned p;

    assign p = 32'(ptr);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req[i] && (i == (p + k) % N)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/glb_bank_arbiter.sv
// Packet-side bank arbiter: round-robin write/read grant to the bank and
// in-order routing of bank read responses back to the issuing requester.
module glb_bank_arbiter
    import global_buffer_param::*;
    import global_buffer_pkg::*;
#(
    parameter int NUM_REQ    = int'(REQ_PCFG) + 1,
    parameter int RD_LATENCY = GLB_RD_LATENCY
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0]                        req_wr_en,
    input  logic [NUM_REQ-1:0][BANK_ADDR_WIDTH-1:0]   req_wr_addr,
    input  logic [NUM_REQ-1:0][BANK_DATA_WIDTH-1:0]   req_wr_data,
    input  logic [NUM_REQ-1:0][BANK_DATA_WIDTH-1:0]   req_wr_data_bit_sel,
    input  logic [NUM_REQ-1:0]                        req_rd_en,
    input  logic [NUM_REQ-1:0][BANK_ADDR_WIDTH-1:0]   req_rd_addr,
    output logic [NUM_REQ-1:0]                        req_ack,
    output logic [BANK_DATA_WIDTH-1:0]                req_rd_data,
    output logic [NUM_REQ-1:0]                        req_rd_data_valid,
    input  logic                                      cfg_busy,
    output logic                                      packet_wr_en,
    output logic [BANK_ADDR_WIDTH-1:0]                packet_wr_addr,
    output logic [BANK_DATA_WIDTH-1:0]                packet_wr_data,
    output logic [BANK_DATA_WIDTH-1:0]                packet_wr_data_bit_sel,
    output logic                                      packet_rd_en,
    output logic [BANK_ADDR_WIDTH-1:0]                packet_rd_addr,
    input  logic [BANK_DATA_WIDTH-1:0]                packet_rd_data,
    input  logic                                      packet_rd_data_valid,
    output logic                                      err_unexpected_rd
);

    localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned N     = NUM_REQ;
    localparam int unsigned LAT   = RD_LATENCY;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] id;
    } tag_t;

    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           gid;
    logic [NUM_REQ-1:0]         active;
    logic [NUM_REQ-1:0]         grant;
    tag_t                       tag_q [LAT];
    tag_t                       tail;
    logic                       rsp_hit;
    logic [BANK_DATA_WIDTH-1:0] rd_data_q;
    logic                       err_q;

    assign active = (req_wr_en | req_rd_en) & {NUM_REQ{~cfg_busy}};

    glb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (active),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign req_ack = grant;

    // A granted requester with both enables set issues its write; the read
    // stays asserted and competes again on a later round.
    always_comb begin
        gid                    = '0;
        packet_wr_en           = 1'b0;
        packet_wr_addr         = '0;
        packet_wr_data         = '0;
        packet_wr_data_bit_sel = '0;
        packet_rd_en           = 1'b0;
        packet_rd_addr         = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                gid = PTR_W'(i);
                if (req_wr_en[i]) begin
                    packet_wr_en           = 1'b1;
                    packet_wr_addr         = req_wr_addr[i];
                    packet_wr_data         = req_wr_data[i];
                    packet_wr_data_bit_sel = req_wr_data_bit_sel[i];
                end else begin
                    packet_rd_en   = 1'b1;
                    packet_rd_addr = req_rd_addr[i];
                end
            end
        end
    end

    assign tail    = tag_q[LAT-1];
    assign rsp_hit = packet_rd_data_valid & tail.valid;

    always_comb begin
        req_rd_data_valid = '0;
        for (int unsigned i = 0; i < N; i++) begin
            req_rd_data_valid[i] = rsp_hit && (tail.id == PTR_W'(i));
        end
    end

    assign req_rd_data       = rsp_hit ? packet_rd_data : rd_data_q;
    assign err_unexpected_rd = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (|grant) begin
                rr_ptr <= (gid == PTR_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
            end
            tag_q[0] <= '{valid: packet_rd_en, id: (packet_rd_en ? gid : '0)};
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (rsp_hit) begin
                rd_data_q <= packet_rd_data;
            end
            // Any disagreement between the tag tail and the bank strobe is a lost or stray response.
            if (packet_rd_data_valid != tail.valid) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/glb_bank_arbiter.md
GLB_BANK_ARBITER -- requirements
Module: glb_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of packet requesters (0=proc, 1=strm, 2=pcfg).
REQ-002 SHALL have parameter RD_LATENCY, default 3, cycles from bank read issue to bank packet_rd_data_valid.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 SHALL have port req_wr_en  in  NUM_REQ  per-requester write request.
REQ-006 SHALL have port req_wr_addr  in  NUM_REQ x BANK_ADDR_WIDTH  per-requester write address.
REQ-007 SHALL have port req_wr_data  in  NUM_REQ x BANK_DATA_WIDTH  per-requester write data.
REQ-008 SHALL have port req_wr_data_bit_sel  in  NUM_REQ x BANK_DATA_WIDTH  per-requester write bit mask.
REQ-009 SHALL have port req_rd_en  in  NUM_REQ  per-requester read request.
REQ-010 SHALL have port req_rd_addr  in  NUM_REQ x BANK_ADDR_WIDTH  per-requester read address.
REQ-011 SHALL have port req_ack  out  NUM_REQ  one-hot grant; request consumed this cycle.
REQ-012 SHALL have port req_rd_data  out  BANK_DATA_WIDTH  shared read response data.
REQ-013 SHALL have port req_rd_data_valid  out  NUM_REQ  one-hot, response belongs to that requester.
REQ-014 SHALL have port cfg_busy  in  1  SRAM-config access active this cycle; bank owned by config.
REQ-015 SHALL have ports packet_wr_en/packet_wr_addr/packet_wr_data/packet_wr_data_bit_sel  out  1/BANK_ADDR_WIDTH/BANK_DATA_WIDTH/BANK_DATA_WIDTH  to glb_bank_ctrl packet write.
REQ-016 SHALL have ports packet_rd_en/packet_rd_addr  out  1/BANK_ADDR_WIDTH  to glb_bank_ctrl packet read.
REQ-017 SHALL have ports packet_rd_data/packet_rd_data_valid  in  BANK_DATA_WIDTH/1  from glb_bank_ctrl.
REQ-018 SHALL have port err_unexpected_rd  out  1  sticky: bank response with no pending read.

Function
REQ-019 Requester i active when req_wr_en[i] or req_rd_en[i]; write wins when both set (read held, re-arbitrated later).
REQ-020 Round-robin: grant the first active requester at or after rr_ptr (wrapping NUM_REQ-1 -> 0); at most one grant per cycle.
REQ-021 On grant to i, rr_ptr <= (i+1) mod NUM_REQ next cycle; with no grant rr_ptr holds.
REQ-022 cfg_busy=1 -> no grant, req_ack=0, packet_wr_en=packet_rd_en=0, rr_ptr holds.
REQ-023 req_ack and packet_* outputs combinational from requests, cfg_busy, rr_ptr; zero-cycle accept; unselected packet_* fields drive 0.
REQ-024 Each granted read pushes {1,i} into a RD_LATENCY-deep tag shift register; every other cycle pushes {0,0}.
REQ-025 packet_rd_data_valid=1 with tag-tail valid -> req_rd_data_valid[tag id]=1, req_rd_data=packet_rd_data, same cycle (total latency RD_LATENCY).
REQ-026 packet_rd_data_valid=1 with tag-tail invalid -> response dropped, err_unexpected_rd set until reset.
REQ-027 Tag-tail valid but packet_rd_data_valid=0 -> tag discarded, err_unexpected_rd set.
REQ-028 req_rd_data holds last delivered value when no response valid.
REQ-029 Back-to-back reads from any mix of requesters, one per cycle, SHALL all be routed in issue order.

Reset
REQ-030 reset=0 asynchronously clears rr_ptr to 0, tag register to all-invalid, err_unexpected_rd, req_rd_data to 0; req_rd_data_valid=0.
REQ-031 Reset mid-operation discards in-flight tags; no response delivered for reads issued before reset.

Structure
REQ-032 BANK_ADDR_WIDTH, BANK_DATA_WIDTH from global_buffer_param; requester-id enum and RD_LATENCY default in global_buffer_pkg.
REQ-033 One sub-module glb_rr_arbiter (NUM_REQ request vector + pointer -> one-hot grant).

Verification
REQ-034 All 3 requesters write every cycle, rr_ptr=0 -> grants 0,1,2,0,1,2; addrs 0x10/0x20/0x30 on packet_wr_addr in that order.
REQ-035 Proc read addr 0x40 at cycle 0 -> packet_rd_en cycle 0; bank data 0xA5 valid cycle 3 -> req_rd_data_valid=3'b001, req_rd_data=0xA5 cycle 3.
REQ-036 cfg_busy=1 cycles 0-4 with strm write pending -> req_ack=0 throughout; strm granted cycle 5.
REQ-037 pcfg wr_en and rd_en both held -> write acked first, read acked on a later grant; response routed to bit 2.
REQ-038 Inject packet_rd_data_valid with no reads issued -> err_unexpected_rd=1 next cycle, held until reset=0.
REQ-039 Reads from 1,2,0 on cycles 0-2, reset=0 at cycle 1 -> no req_rd_data_valid after reset release; rr_ptr=0.
